// File: rtl/spi_pkg.sv
// ============================================================================
// Module : spi_pkg
// Brief  : Shared state encoding and SPI mode-0 constants for spi_master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LEAD      = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_WAIT_NEXT = 3'd3,
    ST_TRAIL     = 3'd4,
    ST_GAP       = 3'd5
  } spi_state_e;

  localparam logic c_CPOL        = 1'b0;
  localparam logic c_CPHA        = 1'b0;
  localparam logic c_SSEL_ACTIVE = 1'b0;

  // States in which a new word may be handed over.
  function automatic logic ready_state(input spi_state_e s);
    return (s == ST_IDLE) || (s == ST_WAIT_NEXT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_gen.sv
// ============================================================================
// Module : spi_clk_gen
// Brief  : SCLK divider: half-period tick, rise/fall strobes, registered SCLK.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick,
  output logic o_rise,
  output logic o_fall,
  output logic o_sclk
);

  localparam int              c_CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

  logic [c_CW-1:0] r_cnt;
  logic            r_sclk;

  assign o_tick = (r_cnt == c_LAST);
  assign o_rise = o_tick & i_run & (r_sclk == c_CPOL);
  assign o_fall = o_tick & i_run & (r_sclk != c_CPOL);
  assign o_sclk = r_sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= c_CPOL;
    end else begin
      if (i_clear || o_tick) r_cnt <= '0;
      else                   r_cnt <= r_cnt + c_CW'(1);
      // SCLK only ever changes here, so it cannot glitch.
      if (o_rise || o_fall) r_sclk <= ~r_sclk;
      else if (i_clear)     r_sclk <= c_CPOL;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// Module : spi_master
// Brief  : SPI mode-0 initiator with multi-word frames, MSB first.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_last,
  output logic             o_rx_valid,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_busy,
  output logic             o_sclk,
  output logic             o_ssel,
  output logic             o_mosi,
  input  logic             i_miso
);

  localparam int              c_BW   = $clog2(WIDTH + 1);
  localparam logic [c_BW-1:0] c_BITS = c_BW'(WIDTH);

  spi_state_e       r_state;
  spi_state_e       w_state_nxt;
  logic             r_tx_ready;
  logic             r_ssel;
  logic             r_mosi;
  logic             r_rx_valid;
  logic             r_last;
  logic [WIDTH-1:0] r_tx_sr;
  logic [WIDTH-1:0] r_rx_sr;
  logic [WIDTH-1:0] r_rx_data;
  logic [c_BW-1:0]  r_bit_cnt;
  logic             w_tick;
  logic             w_rise;
  logic             w_fall;
  logic             w_accept;
  logic             w_done;
  logic             w_run;
  logic             w_clear;

  assign w_accept = i_tx_valid & r_tx_ready;
  assign w_run    = (r_state == ST_SHIFT);
  assign w_done   = w_fall & (r_bit_cnt == c_BITS);
  // Every state change restarts the divider so each phase lasts whole half-periods.
  assign w_clear  = (w_state_nxt != r_state);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_run   (w_run),
    .o_tick  (w_tick),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_sclk  (o_sclk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (w_accept) w_state_nxt = ST_LEAD;
      ST_LEAD:      if (w_tick)   w_state_nxt = ST_SHIFT;
      ST_SHIFT:     if (w_done)   w_state_nxt = r_last ? ST_TRAIL : ST_WAIT_NEXT;
      ST_WAIT_NEXT: if (w_accept) w_state_nxt = ST_SHIFT;
      ST_TRAIL:     if (w_tick)   w_state_nxt = ST_GAP;
      ST_GAP:       if (w_tick)   w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_ready <= 1'b0;
      r_ssel     <= ~c_SSEL_ACTIVE;
      r_mosi     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_last     <= 1'b0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
    end else begin
      // Registered from the next state so ready stays low in the first cycle out of reset.
      r_tx_ready <= ready_state(w_state_nxt);
      r_ssel     <= ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GAP)) ?
                    ~c_SSEL_ACTIVE : c_SSEL_ACTIVE;
      r_rx_valid <= w_done;

      if (w_accept) begin
        r_tx_sr   <= i_tx_data;
        r_mosi    <= i_tx_data[WIDTH-1];
        r_last    <= i_tx_last;
        r_bit_cnt <= '0;
      end else if ((w_state_nxt == ST_GAP) && (r_state != ST_GAP)) begin
        r_mosi <= 1'b0;
      end else if (w_fall && !w_done) begin
        r_tx_sr <= {r_tx_sr[WIDTH-2:0], 1'b0};
        r_mosi  <= r_tx_sr[WIDTH-2];
      end

      if (w_rise) begin
        r_rx_sr   <= {r_rx_sr[WIDTH-2:0], i_miso};
        r_bit_cnt <= r_bit_cnt + c_BW'(1);
      end

      if (w_done) r_rx_data <= r_rx_sr;
    end
  end

  assign o_tx_ready = r_tx_ready;
  assign o_ssel     = r_ssel;
  assign o_mosi     = r_mosi;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module : tb_spi_master
// Brief  : Scoreboard bench for spi_master (CLK_DIV=2 main, CLK_DIV=1 aux).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_master;

  localparam int W   = 8;
  localparam int D   = 2;
  localparam int TMO = 2000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         tx_valid = 1'b0, tx_last = 1'b0;
  logic [W-1:0] tx_data  = '0;
  logic         tx_ready, rx_valid, busy, sclk, ssel, mosi, miso;
  logic [W-1:0] rx_data;

  logic         f_tx_valid = 1'b0, f_tx_last = 1'b0;
  logic [W-1:0] f_tx_data  = '0;
  logic         f_tx_ready, f_rx_valid, f_busy, f_sclk, f_ssel, f_mosi;
  logic [W-1:0] f_rx_data;

  int   miso_mode = 0;  // 0: MISO=MOSI, 1: slave model, 2: constant 0
  logic slave_bit = 1'b0;
  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? slave_bit : 1'b0;

  spi_master #(.WIDTH(W), .CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_tx_valid(tx_valid), .o_tx_ready(tx_ready), .i_tx_data(tx_data), .i_tx_last(tx_last),
    .o_rx_valid(rx_valid), .o_rx_data(rx_data), .o_busy(busy),
    .o_sclk(sclk), .o_ssel(ssel), .o_mosi(mosi), .i_miso(miso)
  );

  spi_master #(.WIDTH(W), .CLK_DIV(1)) dut_fast (
    .clk(clk), .rst_n(rst_n),
    .i_tx_valid(f_tx_valid), .o_tx_ready(f_tx_ready), .i_tx_data(f_tx_data), .i_tx_last(f_tx_last),
    .o_rx_valid(f_rx_valid), .o_rx_data(f_rx_data), .o_busy(f_busy),
    .o_sclk(f_sclk), .o_ssel(f_ssel), .o_mosi(f_mosi), .i_miso(1'b0)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [W-1:0] exp_rx[$];
  logic [W-1:0] exp_tx[$];
  logic [W-1:0] f_exp_rx[$];

  // Slave model: presents the response byte MSB first, next bit after each SCLK fall.
  logic [W-1:0] slave_next  = '0;
  int           slave_loads = 0;
  logic [W-1:0] s_cur       = '0;
  int           s_pos       = 0;
  int           s_seen      = 0;
  logic         s_prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_pos       = 0;
      s_prev_sclk = 1'b0;
      slave_bit   = 1'b0;
    end else begin
      if (s_seen != slave_loads) begin
        s_seen = slave_loads;
        s_cur  = slave_next;
        s_pos  = 0;
      end else if (s_prev_sclk && !sclk) begin
        s_pos++;
      end
      s_prev_sclk = sclk;
      slave_bit   = (s_pos < W) ? s_cur[3'(W - 1 - s_pos)] : 1'b0;
    end
  end

  // Main monitor
  int           cyc = 0, last_rise = 0, bits = 0, ssel_low = 0, words_in_frame = 0;
  int           gap_cnt = 0, ssel_rises = 0, rise_total = 0;
  logic         p_sclk = 1'b0, p_ssel = 1'b1, p_busy = 1'b0, p_rxv = 1'b0;
  logic [W-1:0] mon_word = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      bits = 0; ssel_low = 0; words_in_frame = 0; gap_cnt = 0;
      p_sclk = 1'b0; p_ssel = 1'b1; p_busy = 1'b0; p_rxv = 1'b0;
    end else begin
      if (rx_valid) begin
        check("rx_single_pulse", int'(p_rxv), 0);
        check("rx_expected", int'(exp_rx.size() != 0), 1);
        if (exp_rx.size() != 0) check("rx_data", int'(rx_data), int'(exp_rx.pop_front()));
      end
      if (sclk && !p_sclk) begin
        if (bits > 0) check("sclk_period", cyc - last_rise, 2 * D);
        last_rise = cyc;
        rise_total++;
        mon_word = {mon_word[W-2:0], mosi};
        bits++;
        if (bits == W) begin
          bits = 0;
          words_in_frame++;
          check("mosi_expected", int'(exp_tx.size() != 0), 1);
          if (exp_tx.size() != 0) check("mosi_word", int'(mon_word), int'(exp_tx.pop_front()));
        end
      end
      if (!ssel) ssel_low++;
      if (ssel && !p_ssel) begin
        ssel_rises++;
        if (words_in_frame == 1) check("ssel_low_cycles", ssel_low, (2 + 2 * W) * D);
        ssel_low       = 0;
        words_in_frame = 0;
      end
      if (ssel && busy) gap_cnt++;
      if (p_busy && !busy) begin
        check("deselect_cycles", gap_cnt, D);
        check("ready_after_gap", int'(tx_ready), 1);
        gap_cnt = 0;
      end
      p_sclk = sclk; p_ssel = ssel; p_busy = busy; p_rxv = rx_valid;
    end
  end

  // Monitor for the CLK_DIV=1 instance
  int   f_cyc = 0, f_last = 0, f_bits = 0;
  logic f_p_sclk = 1'b0, f_p_rxv = 1'b0;

  always @(negedge clk) begin
    f_cyc++;
    if (!rst_n) begin
      f_bits = 0; f_p_sclk = 1'b0; f_p_rxv = 1'b0;
    end else begin
      if (f_rx_valid) begin
        check("fast_rx_single_pulse", int'(f_p_rxv), 0);
        check("fast_rx_expected", int'(f_exp_rx.size() != 0), 1);
        if (f_exp_rx.size() != 0) check("fast_rx_data", int'(f_rx_data), int'(f_exp_rx.pop_front()));
      end
      if (f_sclk && !f_p_sclk) begin
        if (f_bits > 0) check("fast_sclk_period", f_cyc - f_last, 2);
        f_last = f_cyc;
        f_bits = (f_bits + 1) % W;
      end
      f_p_sclk = f_sclk; f_p_rxv = f_rx_valid;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic last, input logic [W-1:0] rsp);
    int n;
    exp_tx.push_back(d);
    exp_rx.push_back((miso_mode == 0) ? d : (miso_mode == 1) ? rsp : '0);
    @(negedge clk);
    tx_valid = 1'b1; tx_data = d; tx_last = last;
    n = 0;
    while (!tx_ready && n < TMO) begin @(negedge clk); n++; end
    check("accept_in_time", int'(n < TMO), 1);
    @(posedge clk);
    slave_next = rsp;
    slave_loads++;
    #1 tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_rx.size() != 0) && n < TMO) begin @(negedge clk); n++; end
    check("frame_done_in_time", int'(n < TMO), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, bad, frames;
    repeat (3) @(negedge clk);
    check("reset_ssel", int'(ssel), 1);
    check("reset_sclk", int'(sclk), 0);
    check("reset_mosi", int'(mosi), 0);
    check("reset_tx_ready", int'(tx_ready), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    #1 check("ready_low_before_edge", int'(tx_ready), 0);
    @(negedge clk);
    check("ready_after_first_edge", int'(tx_ready), 1);

    // Loopback single word
    miso_mode = 0;
    send(8'hA5, 1'b1, 8'h00);
    wait_idle();

    // Three-word frame against the slave model, back-to-back offers
    miso_mode = 1;
    base = ssel_rises;
    send(8'h3C, 1'b0, 8'h11);
    send(8'hC3, 1'b0, 8'h22);
    send(8'h0F, 1'b1, 8'h33);
    wait_idle();
    check("ssel_rises_3word", ssel_rises - base, 1);

    // Long stall in WAIT_NEXT
    miso_mode = 0;
    base = ssel_rises;
    send(8'h5A, 1'b0, 8'h00);
    n = 0;
    while ((exp_rx.size() != 0 || !tx_ready) && n < TMO) begin @(negedge clk); n++; end
    check("reach_wait_next", int'(n < TMO), 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ssel || sclk || !tx_ready) bad++;
    end
    check("wait_next_hold", bad, 0);
    send(8'h55, 1'b1, 8'h00);
    wait_idle();
    check("ssel_rises_wait", ssel_rises - base, 1);

    // CLK_DIV=1 instance, MISO tied low
    f_exp_rx.push_back(8'h00);
    @(negedge clk);
    f_tx_valid = 1'b1; f_tx_data = 8'hFF; f_tx_last = 1'b1;
    n = 0;
    while (!f_tx_ready && n < TMO) begin @(negedge clk); n++; end
    check("fast_accept_in_time", int'(n < TMO), 1);
    @(posedge clk);
    #1 f_tx_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while ((f_busy || f_exp_rx.size() != 0) && n < TMO) begin @(negedge clk); n++; end
    check("fast_done_in_time", int'(n < TMO), 1);

    // Reset mid-transfer after the third SCLK rise
    miso_mode = 0;
    base = rise_total;
    send(8'hE7, 1'b1, 8'h00);
    n = 0;
    while (rise_total < base + 3 && n < TMO) begin @(posedge clk); n++; end
    check("third_rise_seen", int'(n < TMO), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ssel", int'(ssel), 1);
    check("abort_sclk", int'(sclk), 0);
    check("abort_mosi", int'(mosi), 0);
    check("abort_rx_valid", int'(rx_valid), 0);
    check("abort_busy", int'(busy), 0);
    exp_rx.delete();
    exp_tx.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(8'h81, 1'b1, 8'h00);
    wait_idle();

    // Randomised frames
    base   = ssel_rises;
    frames = 0;
    for (int f = 0; f < 30; f++) begin
      int len;
      miso_mode = $urandom_range(0, 2);
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) begin
        send(W'($urandom), (i == len - 1), W'($urandom));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
      end
      wait_idle();
      frames++;
    end
    check("ssel_rises_random", ssel_rises - base, frames);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("tx_queue_drained", exp_tx.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
